// File: rtl/eye_pkg.sv
// Shared types and constants for the ALU write-back slice.
// Holds the buffered entry layout and the ALU opcodes that set carry.
package eye_pkg;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 2;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [ADDR_W-1:0] addr;
    } wb_entry_t;

    function automatic logic sets_carry(input logic [3:0] sel);
        return (sel == ALU_ADD) || (sel == ALU_SUB);
    endfunction
endpackage

// File: rtl/alu_writeback_if.sv
// Result-in / write-back-out handshake bundle plus flag outputs.
// master drives ALU results and consumes write-backs; slave is the block.
interface alu_writeback_if;
    import eye_pkg::*;

    logic              res_valid_in;
    logic              res_ready_out;
    logic [DATA_W-1:0] res_in;
    logic              c_in;
    logic [3:0]        alu_sel_in;
    logic [ADDR_W-1:0] rd_addr_in;
    logic              flag_we_in;
    logic              flush_in;
    logic              wb_valid_out;
    logic              wb_ready_in;
    logic [DATA_W-1:0] wb_data_out;
    logic [ADDR_W-1:0] wb_addr_out;
    logic              carry_flag_out;
    logic              zero_flag_out;
    logic              neg_flag_out;

    modport master (
        output res_valid_in, res_in, c_in, alu_sel_in,
        output rd_addr_in, flag_we_in, flush_in, wb_ready_in,
        input  res_ready_out, wb_valid_out, wb_data_out,
        input  wb_addr_out, carry_flag_out, zero_flag_out,
        input  neg_flag_out
    );

    modport slave (
        input  res_valid_in, res_in, c_in, alu_sel_in,
        input  rd_addr_in, flag_we_in, flush_in, wb_ready_in,
        output res_ready_out, wb_valid_out, wb_data_out,
        output wb_addr_out, carry_flag_out, zero_flag_out,
        output neg_flag_out
    );
endinterface

// File: rtl/wb_skid_buf.sv
// Two-entry in-order result buffer; caller gates push/pop by full/empty/flush.
// Storage is cleared on reset so the head reads zero while in reset.
module wb_skid_buf
    import eye_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  logic      push,
    input  logic      pop,
    input  logic      flush,
    input  wb_entry_t din,
    output wb_entry_t dout,
    output logic      full,
    output logic      empty
);
    logic [1:0] r_cnt;
    logic       r_wptr;
    logic       r_rptr;
    wb_entry_t  r_mem [DEPTH];

    assign full  = (r_cnt == 2'(DEPTH));
    assign empty = (r_cnt == 2'd0);
    assign dout  = r_mem[r_rptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= 2'd0;
            r_wptr <= 1'b0;
            r_rptr <= 1'b0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (flush) begin
            r_cnt  <= 2'd0;
            r_wptr <= 1'b0;
            r_rptr <= 1'b0;
        end else begin
            if (push) begin
                r_mem[r_wptr] <= din;
                r_wptr        <= ~r_wptr;
            end
            if (pop) r_rptr <= ~r_rptr;
            r_cnt <= r_cnt + {1'b0, push} - {1'b0, pop};
        end
    end
endmodule

// File: rtl/alu_writeback.sv
// ALU write-back stage: buffers results for the register file and
// maintains carry/zero/negative flags from accepted results.
module alu_writeback
    import eye_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    alu_writeback_if.slave  bus
);
    logic      w_full;
    logic      w_empty;
    logic      w_push;
    logic      w_pop;
    wb_entry_t w_din;
    wb_entry_t w_head;
    logic      r_carry;
    logic      r_zero;
    logic      r_neg;

    // Flush wins over both handshakes so nothing moves on that edge.
    assign w_push = bus.res_valid_in & ~w_full & ~bus.flush_in;
    assign w_pop  = ~w_empty & bus.wb_ready_in & ~bus.flush_in;

    assign w_din.data = bus.res_in;
    assign w_din.addr = bus.rd_addr_in;

    wb_skid_buf u_buf (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_push),
        .pop   (w_pop),
        .flush (bus.flush_in),
        .din   (w_din),
        .dout  (w_head),
        .full  (w_full),
        .empty (w_empty)
    );

    assign bus.res_ready_out  = ~w_full;
    assign bus.wb_valid_out   = ~w_empty;
    assign bus.wb_data_out    = w_head.data;
    assign bus.wb_addr_out    = w_head.addr;
    assign bus.carry_flag_out = r_carry;
    assign bus.zero_flag_out  = r_zero;
    assign bus.neg_flag_out   = r_neg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_carry <= 1'b0;
            r_zero  <= 1'b0;
            r_neg   <= 1'b0;
        end else if (w_push && bus.flag_we_in) begin
            r_zero <= (bus.res_in == '0);
            r_neg  <= bus.res_in[DATA_W-1];
            if (sets_carry(bus.alu_sel_in)) r_carry <= bus.c_in;
        end
    end
endmodule

// File: tb/tb_alu_writeback.sv
// Directed scenarios then random traffic against a queue-based model.
// Inputs change 1 time unit after the rising edge; outputs sampled there too.
module tb_alu_writeback;
    import eye_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   failures = 0;

    wb_entry_t mq[$];
    logic      m_carry, m_zero, m_neg;

    alu_writeback_if bus ();

    alu_writeback dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".valid"}, 32'(bus.wb_valid_out), 32'(mq.size() > 0));
        chk({tag, ".ready"}, 32'(bus.res_ready_out), 32'(mq.size() < 2));
        chk({tag, ".carry"}, 32'(bus.carry_flag_out), 32'(m_carry));
        chk({tag, ".zero"}, 32'(bus.zero_flag_out), 32'(m_zero));
        chk({tag, ".neg"}, 32'(bus.neg_flag_out), 32'(m_neg));
        if (mq.size() > 0) begin
            chk({tag, ".data"}, 32'(bus.wb_data_out), 32'(mq[0].data));
            chk({tag, ".addr"}, 32'(bus.wb_addr_out), 32'(mq[0].addr));
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, ".valid"}, 32'(bus.wb_valid_out), 32'd0);
        chk({tag, ".ready"}, 32'(bus.res_ready_out), 32'd1);
        chk({tag, ".carry"}, 32'(bus.carry_flag_out), 32'd0);
        chk({tag, ".zero"}, 32'(bus.zero_flag_out), 32'd0);
        chk({tag, ".neg"}, 32'(bus.neg_flag_out), 32'd0);
        chk({tag, ".data"}, 32'(bus.wb_data_out), 32'd0);
        chk({tag, ".addr"}, 32'(bus.wb_addr_out), 32'd0);
    endtask

    task automatic model_reset();
        mq.delete();
        m_carry = 1'b0;
        m_zero  = 1'b0;
        m_neg   = 1'b0;
    endtask

    task automatic drive(input logic v, input logic [15:0] d,
                         input logic [3:0] a, input logic [3:0] sel,
                         input logic c, input logic we,
                         input logic rdy, input logic fl);
        bus.res_valid_in = v;
        bus.res_in       = d;
        bus.rd_addr_in   = a;
        bus.alu_sel_in   = sel;
        bus.c_in         = c;
        bus.flag_we_in   = we;
        bus.wb_ready_in  = rdy;
        bus.flush_in     = fl;
    endtask

    // One clock: capture the inputs, let the edge pass, advance the model.
    task automatic cycle(input string tag);
        wb_entry_t e;
        logic push, pop, fl, we, c;
        logic [3:0] sel;
        push   = bus.res_valid_in && (mq.size() < 2);
        pop    = bus.wb_ready_in && (mq.size() > 0);
        fl     = bus.flush_in;
        we     = bus.flag_we_in;
        c      = bus.c_in;
        sel    = bus.alu_sel_in;
        e.data = bus.res_in;
        e.addr = bus.rd_addr_in;
        @(posedge clk);
        #1;
        if (fl) begin
            mq.delete();
        end else begin
            if (pop) void'(mq.pop_front());
            if (push) begin
                mq.push_back(e);
                if (we) begin
                    m_zero = (e.data == 16'h0000);
                    m_neg  = e.data[15];
                    if (sel == 4'd0 || sel == 4'd1) m_carry = c;
                end
            end
        end
        check_model(tag);
    endtask

    initial begin
        rst_n = 1'b0;
        drive(0, 16'h0, 4'h0, ALU_ADD, 0, 0, 0, 0);
        model_reset();
        @(posedge clk);
        #1;
        check_reset("rst");
        rst_n = 1'b1;

        // Push of zero on the first edge after reset release.
        drive(1, 16'h0000, 4'h3, ALU_ADD, 1, 1, 1, 0);
        cycle("s1");
        chk("s1.valid1", 32'(bus.wb_valid_out), 32'd1);
        chk("s1.zero1", 32'(bus.zero_flag_out), 32'd1);
        chk("s1.carry1", 32'(bus.carry_flag_out), 32'd1);
        drive(0, 16'h0, 4'h0, ALU_ADD, 0, 0, 1, 0);
        cycle("s1drain");

        // Fill to two with the consumer stalled.
        drive(1, 16'h8001, 4'h1, ALU_SUB, 0, 1, 0, 0);
        cycle("s2a");
        drive(1, 16'h0002, 4'h2, ALU_ADD, 0, 1, 0, 0);
        cycle("s2b");
        chk("s2.ready0", 32'(bus.res_ready_out), 32'd0);
        chk("s2.head", 32'(bus.wb_data_out), 32'h8001);
        chk("s2.neg", 32'(bus.neg_flag_out), 32'd0);
        drive(1, 16'hFFFF, 4'h7, ALU_ADD, 1, 1, 0, 0);
        cycle("s2refuse");
        chk("s2.refused_carry", 32'(bus.carry_flag_out), 32'd0);
        drive(0, 16'h0, 4'h0, ALU_ADD, 0, 0, 1, 0);
        cycle("s2pop1");
        cycle("s2pop2");

        // Simultaneous push and pop at count 1.
        drive(1, 16'hAAAA, 4'h5, ALU_ADD, 0, 0, 0, 0);
        cycle("s3a");
        drive(1, 16'h5555, 4'h6, ALU_ADD, 0, 0, 1, 0);
        cycle("s3b");
        chk("s3.data", 32'(bus.wb_data_out), 32'h5555);
        chk("s3.cnt1", 32'({bus.wb_valid_out, bus.res_ready_out}), 32'b11);

        // Non-arithmetic opcode leaves carry alone.
        drive(1, 16'hF0F0, 4'h8, 4'b0100, 1, 1, 1, 0);
        cycle("s4");
        chk("s4.carry", 32'(bus.carry_flag_out), 32'd0);
        chk("s4.neg", 32'(bus.neg_flag_out), 32'd1);
        chk("s4.zero", 32'(bus.zero_flag_out), 32'd0);
        drive(0, 16'h0, 4'h0, ALU_ADD, 0, 0, 1, 0);
        cycle("s4drain");

        // Flush at count 2 drops a simultaneous flag-writing push.
        drive(1, 16'h0011, 4'h1, ALU_ADD, 0, 1, 0, 0);
        cycle("s5a");
        drive(1, 16'h0022, 4'h2, ALU_ADD, 0, 1, 0, 0);
        cycle("s5b");
        drive(1, 16'h0000, 4'h3, ALU_ADD, 1, 1, 1, 1);
        cycle("s5flush");
        chk("s5.valid", 32'(bus.wb_valid_out), 32'd0);
        chk("s5.zero", 32'(bus.zero_flag_out), 32'd0);
        chk("s5.carry", 32'(bus.carry_flag_out), 32'd0);

        // Asynchronous reset with two entries buffered.
        drive(1, 16'h8000, 4'h9, ALU_ADD, 1, 1, 0, 0);
        cycle("s6a");
        drive(1, 16'h0000, 4'hA, ALU_SUB, 1, 1, 0, 0);
        cycle("s6b");
        drive(0, 16'h0, 4'h0, ALU_ADD, 0, 0, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_reset("s6async");
        #1 rst_n = 1'b1;

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            logic [15:0] d;
            d = ($urandom % 8 == 0) ? 16'h0000 : 16'($urandom);
            drive(($urandom % 4) != 0, d, 4'($urandom),
                  4'($urandom % 6), 1'($urandom), 1'($urandom),
                  ($urandom % 3) != 0, ($urandom % 16) == 0);
            cycle("rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/alu_writeback.md
ALU_WRITEBACK -- requirements
Module: alu_writeback

Interface
REQ-001 SHALL have parameters: DATA_W, 16, result width; ADDR_W, 4, destination register address width; DEPTH, 2, result buffer entries (fixed at 2).
REQ-002 SHALL use one clock; reset is asynchronous and active-low.
REQ-003 SHALL have ports:
- clk  input  1  sole clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- res_valid_in  input  1  upstream ALU result valid.
- res_ready_out  output  1  block can accept a result.
- res_in  input  DATA_W  ALU result.
- c_in  input  1  ALU carry out.
- alu_sel_in  input  4  ALU opcode that produced res_in.
- rd_addr_in  input  ADDR_W  destination register.
- flag_we_in  input  1  result updates flags.
- flush_in  input  1  synchronous buffer discard.
- wb_valid_out  output  1  write-back entry valid.
- wb_ready_in  input  1  register file accepts entry.
- wb_data_out  output  DATA_W  write-back data.
- wb_addr_out  output  ADDR_W  write-back register.
- carry_flag_out  output  1  carry flag; drives ALU carry input.
- zero_flag_out  output  1  zero flag.
- neg_flag_out  output  1  negative flag.

Function
REQ-004 SHALL accept a result on a rising edge when res_valid_in and res_ready_out are both 1 (push).
REQ-005 SHALL retire the head entry on a rising edge when wb_valid_out and wb_ready_in are both 1 (pop).
REQ-006 SHALL buffer {res_in, rd_addr_in} in a 2-entry in-order FIFO with a 2-bit count (0..2).
REQ-007 SHALL drive res_ready_out = (count < 2), decoded from registered state only, with no combinational path from wb_ready_in.
REQ-008 SHALL drive wb_valid_out = (count > 0), with wb_data_out/wb_addr_out showing the head entry; when count = 0 the data outputs are don't-care.
REQ-009 SHALL give 1-cycle latency: a push into an empty buffer appears on wb_*_out after that edge.
REQ-010 SHALL keep count unchanged on a simultaneous push and pop at count 1, with the new entry becoming head after the pop.
REQ-011 SHALL never push at count 2, because res_ready_out = 0; a pop at count 2 raises res_ready_out on the next cycle.
REQ-012 SHALL wrap read/write pointers modulo 2.
REQ-013 SHALL hold head data stable while wb_valid_out = 1 and wb_ready_in = 0.
REQ-014 SHALL update flags on a push with flag_we_in = 1, at the same edge:
- zero = (res_in == 0).
- neg = res_in[DATA_W-1].
- carry = c_in only if alu_sel_in is ADD (0000) or SUB (0001); otherwise carry is unchanged.
REQ-015 SHALL leave all flags unchanged on a push with flag_we_in = 0.
REQ-016 SHALL, when flush_in = 1 at an edge: set count and pointers to 0, drop any simultaneous push, suppress any pop effect, and retain flags.
REQ-017 SHALL not update flags from a push dropped by flush.

Reset
REQ-018 SHALL, while rst_n = 0, immediately force count = 0, pointers = 0, wb_valid_out = 0, res_ready_out = 1, carry/zero/neg flags = 0, and wb_data_out/wb_addr_out = 0.
REQ-019 SHALL discard buffered entries when reset asserts mid-operation, and SHALL accept a push on the first rising edge after rst_n deasserts.

Structure
REQ-020 SHALL take DATA_W, ADDR_W, the ALU opcode constants (ALU_ADD = 4'b0000, ALU_SUB = 4'b0001) and a wb_entry_t struct {data, addr} from the shared package eye_pkg.
REQ-021 SHALL implement the FIFO as sub-module wb_skid_buf; flag logic stays in alu_writeback.
REQ-022 SHALL contain no latches; all state is clk-registered with asynchronous rst_n.

Verification
REQ-023 Bench SHALL cover these scenarios:
- Reset then push res_in = 16'h0000, flag_we_in = 1, alu_sel_in = ADD, c_in = 1, wb_ready_in = 1 -> next cycle wb_valid_out = 1, data 0, zero = 1, carry = 1, neg = 0.
- wb_ready_in = 0, push 16'h8001 then 16'h0002 -> count 2, res_ready_out = 0, head 16'h8001, neg = 0 (last push), third push refused.
- Count 1 (head 16'hAAAA), simultaneous push 16'h5555 and pop -> wb_data_out = 16'h5555 next cycle, count stays 1.
- Push alu_sel_in = XOR (0100), c_in = 1, carry previously 0 -> carry stays 0; zero/neg follow result.
- flush_in with count 2 and simultaneous push of 16'h0000 with flag_we_in = 1 -> wb_valid_out = 0 next cycle, zero flag unchanged.
- rst_n low mid-stream with count 2 -> outputs reach reset values asynchronously before the next edge.
